// File: rtl/isp_pkg.sv
// Shared types and constants for the ISP frame sequencer.
//   frame_state_t : frame sequencer states
//   cc_coeff_t    : one signed colour-correction coefficient (INT.FRAC)
//   cfg_is_valid  : crop-versus-frame geometry check used when start is requested
package isp_pkg;

  localparam int CC_INT_BITS  = 6;
  localparam int CC_FRAC_BITS = 6;
  localparam int CC_W         = CC_INT_BITS + CC_FRAC_BITS;

  localparam int DEFAULT_FLUSH_CYCLES   = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

  typedef logic signed [CC_W-1:0] cc_coeff_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } frame_state_t;

  // Crop must be non-empty and fit inside the raw frame.
  function automatic logic cfg_is_valid(input logic [15:0] fwidth,
                                        input logic [15:0] fheight,
                                        input logic [15:0] crop_width,
                                        input logic [15:0] crop_height);
    return (crop_width != 16'd0) && (crop_height != 16'd0) &&
           (crop_width <= fwidth) && (crop_height <= fheight);
  endfunction

endpackage

// File: rtl/isp_cfg_shadow.sv
// Configuration validation and shadow capture for one frame.
//   clk, reset       : clock, asynchronous active-high reset
//   capture          : load every cfg_* into sh_* on this cycle
//   cfg_*            : live configuration inputs
//   cfg_valid        : combinational geometry check of the live configuration
//   sh_*             : configuration frozen for the current/last frame
//   expected         : crop_width*crop_height captured alongside the shadows
module isp_cfg_shadow
  import isp_pkg::*;
#(
  parameter int INT_BITS  = CC_INT_BITS,
  parameter int FRAC_BITS = CC_FRAC_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                capture,
  input  logic [15:0]                         cfg_fwidth,
  input  logic [15:0]                         cfg_fheight,
  input  logic [15:0]                         cfg_crop_width,
  input  logic [15:0]                         cfg_crop_height,
  input  logic [15:0]                         cfg_wb_mult,
  input  logic [15:0]                         cfg_cblack,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] cfg_cc_coeff [9],
  output logic                                cfg_valid,
  output logic [15:0]                         sh_fwidth,
  output logic [15:0]                         sh_fheight,
  output logic [15:0]                         sh_crop_width,
  output logic [15:0]                         sh_crop_height,
  output logic [15:0]                         sh_wb_mult,
  output logic [15:0]                         sh_cblack,
  output logic signed [INT_BITS+FRAC_BITS-1:0] sh_cc_coeff [9],
  output logic [31:0]                         expected
);

  assign cfg_valid = cfg_is_valid(cfg_fwidth, cfg_fheight, cfg_crop_width, cfg_crop_height);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_fwidth      <= '0;
      sh_fheight     <= '0;
      sh_crop_width  <= '0;
      sh_crop_height <= '0;
      sh_wb_mult     <= '0;
      sh_cblack      <= '0;
      for (int i = 0; i < 9; i++) sh_cc_coeff[i] <= '0;
      expected       <= '0;
    end else if (capture) begin
      sh_fwidth      <= cfg_fwidth;
      sh_fheight     <= cfg_fheight;
      sh_crop_width  <= cfg_crop_width;
      sh_crop_height <= cfg_crop_height;
      sh_wb_mult     <= cfg_wb_mult;
      sh_cblack      <= cfg_cblack;
      for (int i = 0; i < 9; i++) sh_cc_coeff[i] <= cfg_cc_coeff[i];
      // 16x16 unsigned product always fits in 32 bits.
      expected       <= 32'(cfg_crop_width) * 32'(cfg_crop_height);
    end
  end

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame-level sequencer for the demosaic/white-balance -> colour-conversion pipe.
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : frame request (IDLE only) and frame termination
//   cfg_*               : per-frame configuration, captured in LOAD
//   pipe_data_v/done    : pixel-valid and frame-done from colour conversion
//   pipe_reset          : holds the pipeline in reset outside RUN
//   sh_*                : shadowed configuration driving the pipeline
//   busy                : high in every state except IDLE
//   cfg_err             : one-cycle pulse when start is rejected
//   frame_done          : one-cycle end-of-frame pulse
//   st_aborted/timeout/size_err, pix_count, frame_count : frame status
module isp_frame_ctrl
  import isp_pkg::*;
#(
  parameter int INT_BITS       = CC_INT_BITS,
  parameter int FRAC_BITS      = CC_FRAC_BITS,
  parameter int FLUSH_CYCLES   = DEFAULT_FLUSH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [15:0]                         cfg_fwidth,
  input  logic [15:0]                         cfg_fheight,
  input  logic [15:0]                         cfg_crop_width,
  input  logic [15:0]                         cfg_crop_height,
  input  logic [15:0]                         cfg_wb_mult,
  input  logic [15:0]                         cfg_cblack,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] cfg_cc_coeff [9],
  input  logic                                pipe_data_v,
  input  logic                                pipe_done,
  output logic                                pipe_reset,
  output logic [15:0]                         sh_fwidth,
  output logic [15:0]                         sh_fheight,
  output logic [15:0]                         sh_crop_width,
  output logic [15:0]                         sh_crop_height,
  output logic [15:0]                         sh_wb_mult,
  output logic [15:0]                         sh_cblack,
  output logic signed [INT_BITS+FRAC_BITS-1:0] sh_cc_coeff [9],
  output logic                                busy,
  output logic                                cfg_err,
  output logic                                frame_done,
  output logic                                st_aborted,
  output logic                                st_timeout,
  output logic                                st_size_err,
  output logic [CNT_W-1:0]                    pix_count,
  output logic [CNT_W-1:0]                    frame_count
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t   state;
  logic [FL_W-1:0] flush_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            cfg_valid;
  logic [31:0]     expected;
  logic [CNT_W-1:0] pix_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  isp_cfg_shadow #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_shadow (
    .clk             (clk),
    .reset           (reset),
    .capture         (state == ST_LOAD),
    .cfg_fwidth      (cfg_fwidth),
    .cfg_fheight     (cfg_fheight),
    .cfg_crop_width  (cfg_crop_width),
    .cfg_crop_height (cfg_crop_height),
    .cfg_wb_mult     (cfg_wb_mult),
    .cfg_cblack      (cfg_cblack),
    .cfg_cc_coeff    (cfg_cc_coeff),
    .cfg_valid       (cfg_valid),
    .sh_fwidth       (sh_fwidth),
    .sh_fheight      (sh_fheight),
    .sh_crop_width   (sh_crop_width),
    .sh_crop_height  (sh_crop_height),
    .sh_wb_mult      (sh_wb_mult),
    .sh_cblack       (sh_cblack),
    .sh_cc_coeff     (sh_cc_coeff),
    .expected        (expected)
  );

  // Pixel count including a pixel that arrives on this cycle, so a pixel
  // coincident with pipe_done is part of the size comparison.
  assign pix_next = sat_inc(pix_count, pipe_data_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pipe_reset  <= 1'b1;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      frame_done  <= 1'b0;
      st_aborted  <= 1'b0;
      st_timeout  <= 1'b0;
      st_size_err <= 1'b0;
      pix_count   <= '0;
      frame_count <= '0;
      flush_cnt   <= '0;
      idle_cnt    <= '0;
    end else begin
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_valid) begin
              state       <= ST_LOAD;
              busy        <= 1'b1;
              pix_count   <= '0;
              st_aborted  <= 1'b0;
              st_timeout  <= 1'b0;
              st_size_err <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        // Shadows are captured by the sub-module on this cycle even when
        // abort is seen here.
        ST_LOAD: begin
          if (abort) begin
            st_aborted  <= 1'b1;
            state       <= ST_DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (abort) begin
            st_aborted  <= 1'b1;
            state       <= ST_DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) begin
            state      <= ST_RUN;
            pipe_reset <= 1'b0;
            idle_cnt   <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        // Priority: completion, then abort, then timeout.
        ST_RUN: begin
          pix_count <= pix_next;
          idle_cnt  <= pipe_data_v ? '0 : idle_cnt + 1'b1;
          if (pipe_done || abort || (idle_cnt == IW'(TIMEOUT_CYCLES))) begin
            state       <= ST_DONE;
            pipe_reset  <= 1'b1;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            if (pipe_done) begin
              st_size_err <= (64'(pix_next) != 64'(expected));
            end else if (abort) begin
              st_aborted <= 1'b1;
            end else begin
              st_timeout <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          pipe_reset <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isp_frame_ctrl.sv
module tb_isp_frame_ctrl;

  localparam int FLUSH = 4;
  localparam int TO    = 16;
  localparam int CNT_W = 32;
  localparam int CW    = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pipe_data_v = 1'b0;
  logic pipe_done = 1'b0;
  logic [15:0] cfg_fwidth = '0, cfg_fheight = '0, cfg_crop_width = '0, cfg_crop_height = '0;
  logic [15:0] cfg_wb_mult = '0, cfg_cblack = '0;
  logic signed [CW-1:0] cfg_cc_coeff [9];

  logic pipe_reset, busy, cfg_err, frame_done, st_aborted, st_timeout, st_size_err;
  logic [15:0] sh_fwidth, sh_fheight, sh_crop_width, sh_crop_height, sh_wb_mult, sh_cblack;
  logic signed [CW-1:0] sh_cc_coeff [9];
  logic [CNT_W-1:0] pix_count, frame_count;
  logic [95:0] sh_all;

  logic [95:0] exp_sh;
  logic signed [CW-1:0] exp_cc [9];

  typedef struct {
    logic [31:0] pix;
    logic        ab;
    logic        to;
    logic        se;
    logic [31:0] fc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  isp_frame_ctrl #(
    .INT_BITS(6), .FRAC_BITS(6), .FLUSH_CYCLES(FLUSH), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_fwidth(cfg_fwidth), .cfg_fheight(cfg_fheight),
    .cfg_crop_width(cfg_crop_width), .cfg_crop_height(cfg_crop_height),
    .cfg_wb_mult(cfg_wb_mult), .cfg_cblack(cfg_cblack), .cfg_cc_coeff(cfg_cc_coeff),
    .pipe_data_v(pipe_data_v), .pipe_done(pipe_done), .pipe_reset(pipe_reset),
    .sh_fwidth(sh_fwidth), .sh_fheight(sh_fheight),
    .sh_crop_width(sh_crop_width), .sh_crop_height(sh_crop_height),
    .sh_wb_mult(sh_wb_mult), .sh_cblack(sh_cblack), .sh_cc_coeff(sh_cc_coeff),
    .busy(busy), .cfg_err(cfg_err), .frame_done(frame_done),
    .st_aborted(st_aborted), .st_timeout(st_timeout), .st_size_err(st_size_err),
    .pix_count(pix_count), .frame_count(frame_count)
  );

  assign sh_all = {sh_fwidth, sh_fheight, sh_crop_width, sh_crop_height, sh_wb_mult, sh_cblack};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "bench timeout");
  end

  // Scoreboard: every frame_done pops the status the bench predicted for it.
  always @(negedge clk) begin
    if (!reset && frame_done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_frame_done: got frame_done with no frame outstanding");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({pix_count, st_aborted, st_timeout, st_size_err, frame_count} !==
            {e.pix, e.ab, e.to, e.se, e.fc}) begin
          errors++;
          $display("FAIL sb_frame_status: got pix=%0d ab=%0b to=%0b se=%0b fc=%0d, expected pix=%0d ab=%0b to=%0b se=%0b fc=%0d",
                   pix_count, st_aborted, st_timeout, st_size_err, frame_count,
                   e.pix, e.ab, e.to, e.se, e.fc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] fw, input logic [15:0] fh,
                         input logic [15:0] cw, input logic [15:0] ch,
                         input logic [15:0] wb, input logic [15:0] cb, input int seed);
    cfg_fwidth = fw; cfg_fheight = fh; cfg_crop_width = cw; cfg_crop_height = ch;
    cfg_wb_mult = wb; cfg_cblack = cb;
    for (int i = 0; i < 9; i++) cfg_cc_coeff[i] = CW'(seed * 37 - i * 301);
  endtask

  // Record the live configuration as the shadow contents the next LOAD must produce.
  task automatic latch_exp();
    exp_sh = {cfg_fwidth, cfg_fheight, cfg_crop_width, cfg_crop_height, cfg_wb_mult, cfg_cblack};
    for (int i = 0; i < 9; i++) exp_cc[i] = cfg_cc_coeff[i];
  endtask

  // Start a frame at cycle 0 and return just after the edge entering RUN (cycle 6).
  task automatic start_to_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1 + FLUSH) tick();
  endtask

  task automatic test_reset();
    bit cc_ok;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({pipe_reset, busy, cfg_err, frame_done, st_aborted, st_timeout, st_size_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got {prst,busy,err,fd,ab,to,se}=%b, expected 1000000",
               {pipe_reset, busy, cfg_err, frame_done, st_aborted, st_timeout, st_size_err});
    end
    checks++;
    if ({pix_count, frame_count, sh_all} !== '0) begin
      errors++;
      $display("FAIL reset_counts_shadow: got pix=%0d fc=%0d sh=%h, expected all zero",
               pix_count, frame_count, sh_all);
    end
    cc_ok = 1'b1;
    for (int i = 0; i < 9; i++) if (sh_cc_coeff[i] !== '0) cc_ok = 1'b0;
    checks++;
    if (!cc_ok) begin
      errors++;
      $display("FAIL reset_cc: got sh_cc_coeff[0]=%0d, expected all zero", sh_cc_coeff[0]);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    bit hold, cc_ok;
    set_cfg(16'd8, 16'd8, 16'd4, 16'd2, 16'h0123, 16'h0040, 5);
    latch_exp();
    sb.push_back('{pix: 8, ab: 1'b0, to: 1'b0, se: 1'b0, fc: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, pipe_reset} !== 2'b11) begin
      errors++;
      $display("FAIL nominal_load: got busy=%0b pipe_reset=%0b, expected 1 1", busy, pipe_reset);
    end
    hold = 1'b1;
    for (int k = 2; k <= 1 + FLUSH; k++) begin
      tick();
      @(negedge clk);
      if (pipe_reset !== 1'b1) hold = 1'b0;
      if (k == 2) begin
        checks++;
        if (sh_all !== exp_sh) begin
          errors++;
          $display("FAIL nominal_shadow: got %h, expected %h", sh_all, exp_sh);
        end
        cc_ok = 1'b1;
        for (int i = 0; i < 9; i++) if (sh_cc_coeff[i] !== exp_cc[i]) cc_ok = 1'b0;
        checks++;
        if (!cc_ok) begin
          errors++;
          $display("FAIL nominal_cc_shadow: got cc[8]=%0d, expected %0d", sh_cc_coeff[8], exp_cc[8]);
        end
      end
    end
    checks++;
    if (!hold) begin
      errors++;
      $display("FAIL nominal_flush_hold: got pipe_reset low during flush, expected 1");
    end
    tick();
    @(negedge clk);
    checks++;
    if (pipe_reset !== 1'b0) begin
      errors++;
      $display("FAIL nominal_release_cycle6: got pipe_reset=%0b, expected 0", pipe_reset);
    end
    pipe_data_v = 1'b1;
    repeat (8) tick();
    pipe_data_v = 1'b0;
    pipe_done = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_fd_early: got frame_done=%0b, expected 0", frame_done);
    end
    tick();
    pipe_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_done, st_size_err, pix_count, frame_count} !== {1'b1, 1'b0, 32'd8, 32'd1}) begin
      errors++;
      $display("FAIL nominal_done: got fd=%0b se=%0b pix=%0d fc=%0d, expected 1 0 8 1",
               frame_done, st_size_err, pix_count, frame_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, pipe_reset, frame_done} !== 3'b010) begin
      errors++;
      $display("FAIL nominal_back_idle: got busy=%0b prst=%0b fd=%0b, expected 0 1 0",
               busy, pipe_reset, frame_done);
    end
  endtask

  task automatic test_bad_config();
    logic [15:0] bad [3][4];
    bad[0] = '{16'd8, 16'd8, 16'd0, 16'd2};
    bad[1] = '{16'd8, 16'd8, 16'd4, 16'd9};
    bad[2] = '{16'd8, 16'd8, 16'd9, 16'd2};
    for (int n = 0; n < 3; n++) begin
      set_cfg(bad[n][0], bad[n][1], bad[n][2], bad[n][3], 16'h0777, 16'h0011, 9 + n);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({cfg_err, busy} !== 2'b10) begin
        errors++;
        $display("FAIL bad_cfg_pulse%0d: got cfg_err=%0b busy=%0b, expected 1 0", n, cfg_err, busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({cfg_err, busy, sh_all, pix_count} !== {2'b00, exp_sh, 32'd8}) begin
        errors++;
        $display("FAIL bad_cfg_after%0d: got cfg_err=%0b busy=%0b sh=%h pix=%0d, expected 0 0 %h 8",
                 n, cfg_err, busy, sh_all, pix_count, exp_sh);
      end
    end
  endtask

  task automatic test_size_mismatch();
    // Crop equal to the frame size is the largest legal geometry.
    set_cfg(16'd4, 16'd2, 16'd4, 16'd2, 16'h0100, 16'h0000, 21);
    latch_exp();
    sb.push_back('{pix: 7, ab: 1'b0, to: 1'b0, se: 1'b1, fc: 2});
    start_to_run();
    for (int i = 0; i < 14; i++) begin
      pipe_data_v = (i % 2 == 0);
      tick();
    end
    pipe_data_v = 1'b0;
    pipe_done = 1'b1;
    tick();
    pipe_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_done, st_size_err, pix_count} !== {1'b1, 1'b1, 32'd7}) begin
      errors++;
      $display("FAIL size_mismatch: got fd=%0b se=%0b pix=%0d, expected 1 1 7",
               frame_done, st_size_err, pix_count);
    end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    bit hold;
    set_cfg(16'd8, 16'd8, 16'd4, 16'd2, 16'h0200, 16'h0008, 33);
    latch_exp();
    sb.push_back('{pix: 0, ab: 1'b1, to: 1'b0, se: 1'b0, fc: 3});
    hold = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pipe_data_v = 1'b1;
    @(negedge clk);
    if (pipe_reset !== 1'b1) hold = 1'b0;
    tick();
    abort = 1'b1;
    @(negedge clk);
    if (pipe_reset !== 1'b1) hold = 1'b0;
    tick();
    abort = 1'b0;
    pipe_data_v = 1'b0;
    @(negedge clk);
    if (pipe_reset !== 1'b1) hold = 1'b0;
    checks++;
    if ({frame_done, st_aborted, st_size_err, sh_all} !== {3'b110, exp_sh}) begin
      errors++;
      $display("FAIL abort_flush: got fd=%0b ab=%0b se=%0b sh=%h, expected 1 1 0 %h",
               frame_done, st_aborted, st_size_err, sh_all, exp_sh);
    end
    tick();
    @(negedge clk);
    if (pipe_reset !== 1'b1) hold = 1'b0;
    checks++;
    if (!hold || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush_prst: got hold=%0b busy=%0b, expected 1 0", hold, busy);
    end

    sb.push_back('{pix: 8, ab: 1'b0, to: 1'b0, se: 1'b0, fc: 4});
    start_to_run();
    pipe_data_v = 1'b1;
    repeat (7) tick();
    // Last pixel, completion and abort all on the same cycle.
    pipe_done = 1'b1;
    abort = 1'b1;
    tick();
    pipe_data_v = 1'b0;
    pipe_done = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_done, st_aborted, pix_count} !== {1'b1, 1'b0, 32'd8}) begin
      errors++;
      $display("FAIL abort_with_done: got fd=%0b ab=%0b pix=%0d, expected 1 0 8",
               frame_done, st_aborted, pix_count);
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    bit ok;
    set_cfg(16'd8, 16'd8, 16'd4, 16'd2, 16'h0300, 16'h0010, 45);
    latch_exp();
    sb.push_back('{pix: 0, ab: 1'b0, to: 1'b1, se: 1'b0, fc: 5});
    start_to_run();
    ok = 1'b1;
    for (int k = 0; k <= TO + 1; k++) begin
      @(negedge clk);
      if (frame_done !== (k == TO + 1)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_latency: got frame_done off cycle %0d after RUN entry", TO + 1);
    end
    checks++;
    if ({st_timeout, st_size_err, st_aborted} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_status: got to=%0b se=%0b ab=%0b, expected 1 0 0",
               st_timeout, st_size_err, st_aborted);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_run();
    bit cc_ok;
    set_cfg(16'd16, 16'd8, 16'd8, 16'd4, 16'h0456, 16'h0020, 57);
    latch_exp();
    start_to_run();
    pipe_data_v = 1'b1;
    repeat (3) tick();
    pipe_data_v = 1'b0;
    set_cfg(16'd4, 16'd4, 16'd2, 16'd2, 16'h0999, 16'h0099, 71);
    @(negedge clk);
    cc_ok = 1'b1;
    for (int i = 0; i < 9; i++) if (sh_cc_coeff[i] !== exp_cc[i]) cc_ok = 1'b0;
    checks++;
    if ({pix_count, sh_all, pipe_reset, cc_ok} !== {32'd3, exp_sh, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL run_cfg_ignored: got pix=%0d sh=%h prst=%0b cc_ok=%0b, expected 3 %h 0 1",
               pix_count, sh_all, pipe_reset, cc_ok, exp_sh);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    cc_ok = 1'b1;
    for (int i = 0; i < 9; i++) if (sh_cc_coeff[i] !== '0) cc_ok = 1'b0;
    checks++;
    if ({pipe_reset, busy, pix_count, frame_count, sh_all, cc_ok} !==
        {1'b1, 1'b0, 32'd0, 32'd0, 96'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got prst=%0b busy=%0b pix=%0d fc=%0d sh=%h cc_ok=%0b, expected 1 0 0 0 0 1",
               pipe_reset, busy, pix_count, frame_count, sh_all, cc_ok);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({busy, pipe_reset, frame_done} !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%0b prst=%0b fd=%0b, expected 0 1 0",
               busy, pipe_reset, frame_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) cfg_cc_coeff[i] = '0;
    test_reset();
    test_nominal();
    test_bad_config();
    test_size_mismatch();
    test_abort();
    test_timeout();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d frames without frame_done, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isp_frame_ctrl.md
Name: isp_frame_ctrl

Overview:
Frame-level sequencer for the demosaic/white-balance to colour-conversion pipeline. It validates per-frame configuration and captures it into shadow registers. It holds the pipeline in reset between frames and releases it for exactly one frame. It then monitors output pixels and completion, and reports per-frame status (abort, timeout, pixel-count mismatch).

Parameters:
INT_BITS, 6, integer bits of each colour-correction coefficient
FRAC_BITS, 6, fractional bits of each colour-correction coefficient
FLUSH_CYCLES, 4, cycles pipe_reset stays high after config capture (min 1)
TIMEOUT_CYCLES, 1048576, max cycles in RUN with no pipe_data_v before timeout
CNT_W, 32, width of pixel and frame counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  request one frame; sampled in IDLE only
abort  in  1  terminate current frame
cfg_fwidth, cfg_fheight  in  16 each  raw frame size
cfg_crop_width, cfg_crop_height  in  16 each  output size
cfg_wb_mult, cfg_cblack  in  16 each  white-balance gain, black level
cfg_cc_coeff  in  9x(INT_BITS+FRAC_BITS) signed  colour matrix
pipe_data_v  in  1  pixel-valid from colour conversion
pipe_done  in  1  frame-done from colour conversion
pipe_reset  out  1  reset to the pipeline
sh_fwidth, sh_fheight, sh_crop_width, sh_crop_height, sh_wb_mult, sh_cblack  out  16 each  shadowed config
sh_cc_coeff  out  9x(INT_BITS+FRAC_BITS)  shadowed matrix
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse when start is rejected
frame_done  out  1  one-cycle end-of-frame pulse
st_aborted, st_timeout, st_size_err  out  1 each  frame status
pix_count  out  CNT_W  pixels counted in current/last frame
frame_count  out  CNT_W  frames completed, including aborted ones

Behaviour:
- Reset values: pipe_reset=1; every other output 0, including all shadow registers. Reset mid-frame returns to IDLE immediately with these values.
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE: pipe_reset=1.
  - Start is valid unless crop_width==0, crop_height==0, crop_width>fwidth, or crop_height>fheight.
  - start with valid cfg: go to LOAD; clear pix_count and the st_* flags.
  - start with invalid cfg: pulse cfg_err next cycle; stay in IDLE; status unchanged.
- LOAD (1 cycle): capture every cfg_* into sh_*; compute expected = crop_width*crop_height (32-bit, no overflow possible). Shadows stay stable until the next LOAD; cfg_* changes in other states are ignored.
- FLUSH: pipe_reset=1 for FLUSH_CYCLES cycles, then RUN.
- Timing: start sampled at cycle 0 gives LOAD at cycle 1, FLUSH at cycles 2..1+FLUSH_CYCLES, and pipe_reset low from cycle 2+FLUSH_CYCLES.
- RUN: pipe_reset=0.
  - pix_count increments on each pipe_data_v cycle and saturates at all-ones.
  - The idle counter clears on pipe_data_v and otherwise increments.
  - pipe_done: go to DONE.
  - Idle counter reaches TIMEOUT_CYCLES: set st_timeout, go to DONE.
  - abort: set st_aborted, go to DONE.
- abort in LOAD or FLUSH: set st_aborted, go to DONE; shadows keep whatever was captured.
- Simultaneous events in RUN:
  - pipe_done with abort: completion wins, st_aborted=0.
  - pipe_done with pipe_data_v: that pixel is counted.
  - pipe_done with timeout: completion wins.
- DONE (1 cycle): frame_done=1; pipe_reset=1; frame_count++ (wraps).
  - st_size_err = (pix_count != expected), set only if neither aborted nor timed out.
  - st_* and pix_count are held until the next accepted start.
  - Next state is IDLE.
- Frame-done latency: frame_done rises exactly 1 cycle after the pipe_done sample.
- start outside IDLE is ignored. pipe_done/pipe_data_v outside RUN are ignored.

Decomposition:
- Package isp_pkg holds:
  - state enum frame_state_t;
  - cc_coeff_t typedef, signed [INT_BITS+FRAC_BITS-1:0];
  - constants DEFAULT_FLUSH_CYCLES and DEFAULT_TIMEOUT_CYCLES.
- One natural sub-module, isp_cfg_shadow: validation plus capture registers.
- FSM, counters and status logic stay in the top level.

Test Plan:
1. Nominal frame: fwidth=8, fheight=8, crop 4x2, FLUSH_CYCLES=4, start at cycle 0 -> pipe_reset low at cycle 6. Drive 8 pipe_data_v, then pipe_done -> frame_done the next cycle, pix_count=8, st_size_err=0, frame_count=1.
2. Bad config: crop_width=0 (or crop_height=9 with fheight=8) -> cfg_err pulses once, busy stays 0, shadows unchanged.
3. Size mismatch: crop 4x2, only 7 pixels before pipe_done -> st_size_err=1, frame_done=1.
4. Abort in FLUSH and abort+pipe_done in RUN -> first gives st_aborted=1, pipe_reset never drops; second gives st_aborted=0 (completion wins).
5. Timeout: TIMEOUT_CYCLES=16, no pipe_data_v in RUN -> st_timeout=1 and frame_done 17 cycles after RUN entry, st_size_err=0.
6. Async reset asserted mid-RUN with pix_count=3 -> outputs at reset values immediately (pipe_reset=1, sh_*=0). Changing cfg_* during RUN before the reset -> sh_* unchanged.
